// File: rtl/rst_sequencer.sv
// Central reset sequencer: synchronizes POR deassertion, merges sw/wdt requests,
// and releases NUM_DOMAINS active-low resets in order behind a sticky cause register.
module rst_sequencer #(
  parameter int NUM_DOMAINS = 3,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGE_GAP   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sw_rst_req,
  input  logic                   wdt_rst_req,
  input  logic                   cause_clr,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic [2:0]             rst_cause
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]       GAP_LAST  = CNT_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [NUM_DOMAINS-1:0] DOM_NONE  = {NUM_DOMAINS{1'b0}};
  localparam logic [NUM_DOMAINS-1:0] DOM_ALL   = {NUM_DOMAINS{1'b1}};
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE   = NUM_DOMAINS'(1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rst_sync_n;
  logic                   w_req;

  state_t                 r_state,  w_state_nxt;
  logic [CNT_W-1:0]       r_cnt,    w_cnt_nxt;
  logic [IDX_W-1:0]       r_idx,    w_idx_nxt;
  logic [NUM_DOMAINS-1:0] r_dom,    w_dom_nxt;
  logic                   r_busy,   w_busy_nxt;
  logic                   r_done,   w_done_nxt;
  logic [2:0]             r_cause,  w_cause_nxt;
  logic [2:0]             w_cause_set;

  assign w_rst_sync_n = r_sync[SYNC_STAGES-1];
  assign w_req        = sw_rst_req | wdt_rst_req;

  // Deassertion synchronizer: clears at once, fills with ones after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Sequencer next state: hold count, staged release, and request handling
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_dom_nxt   = r_dom;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_HOLD: begin
        w_dom_nxt  = DOM_NONE;
        w_busy_nxt = 1'b1;
        w_idx_nxt  = {IDX_W{1'b0}};
        if (w_req) begin
          w_cnt_nxt = {CNT_W{1'b0}};
        end else if (w_rst_sync_n) begin
          if (r_cnt == HOLD_LAST) begin
            w_cnt_nxt = {CNT_W{1'b0}};
            w_dom_nxt = DOM_ONE;
            if (NUM_DOMAINS == 1) begin
              w_state_nxt = ST_RUN;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_RELEASE;
              w_idx_nxt   = IDX_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = {CNT_W{1'b0}};
        end
      end
      ST_RELEASE: begin
        if (w_req) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_dom_nxt   = DOM_NONE;
          w_busy_nxt  = 1'b1;
        end else if (r_cnt == GAP_LAST) begin
          w_cnt_nxt = {CNT_W{1'b0}};
          w_dom_nxt = r_dom | (DOM_ONE << r_idx);
          if (r_idx == IDX_LAST) begin
            w_state_nxt = ST_RUN;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (w_req) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_dom_nxt   = DOM_NONE;
          w_busy_nxt  = 1'b1;
        end else begin
          w_dom_nxt  = DOM_ALL;
          w_busy_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = {CNT_W{1'b0}};
        w_idx_nxt   = {IDX_W{1'b0}};
        w_dom_nxt   = DOM_NONE;
        w_busy_nxt  = 1'b1;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HOLD;
      r_cnt   <= {CNT_W{1'b0}};
      r_idx   <= {IDX_W{1'b0}};
      r_dom   <= DOM_NONE;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_dom   <= w_dom_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Cause update: a clear in the same cycle as a request keeps only the request bits
  always_comb begin
    w_cause_set = {wdt_rst_req, sw_rst_req, 1'b0};
    if (cause_clr) begin
      w_cause_nxt = w_cause_set;
    end else begin
      w_cause_nxt = r_cause | w_cause_set;
    end
  end

  // Sticky cause register; only the external reset restores the POR bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cause <= 3'b001;
    end else begin
      r_cause <= w_cause_nxt;
    end
  end

  assign dom_rst_n = r_dom;
  assign seq_busy  = r_busy;
  assign seq_done  = r_done;
  assign rst_cause = r_cause;

  rst_sequencer_chk #(
    .NUM_DOMAINS (NUM_DOMAINS)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .dom_rst_n (r_dom),
    .seq_busy  (r_busy),
    .seq_done  (r_done)
  );

endmodule

// Output invariants: completion and idle both imply every domain is released.
module rst_sequencer_chk #(
  parameter int NUM_DOMAINS = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic [NUM_DOMAINS-1:0] dom_rst_n,
  input logic                   seq_busy,
  input logic                   seq_done
);

  a_done_released: assert property (@(posedge clk) disable iff (!rst_n)
    seq_done |-> ((&dom_rst_n) && seq_busy));

  a_idle_released: assert property (@(posedge clk) disable iff (!rst_n)
    !seq_busy |-> (&dom_rst_n));

endmodule

// File: tb/tb_rst_sequencer.sv
// Randomized self-checking bench for rst_sequencer; expected outputs come from
// release-edge arithmetic (base + HOLD + i*GAP) rather than a state machine.
module tb_rst_sequencer;

  localparam int P_N    = 3;
  localparam int P_SYNC = 2;
  localparam int P_HOLD = 8;
  localparam int P_GAP  = 4;

  logic       clk;
  logic       rst_n, sw_rst_req, wdt_rst_req, cause_clr;
  logic [2:0] dom_rst_n;
  logic       seq_busy, seq_done;
  logic [2:0] rst_cause;

  logic       rst_n_b, sw_b, wdt_b, clr_b;
  logic [0:0] dom_b;
  logic       busy_b, done_b;
  logic [2:0] cause_b;

  int n_checks = 0;
  int n_pass   = 0;

  int         m_n;
  int         m_base;
  logic [2:0] m_cause;
  logic [2:0] e_dom;
  logic       e_busy, e_done;
  logic [2:0] e_cause;

  rst_sequencer #(
    .NUM_DOMAINS (P_N), .SYNC_STAGES (P_SYNC), .HOLD_CYCLES (P_HOLD), .STAGE_GAP (P_GAP)
  ) dut (
    .clk (clk), .rst_n (rst_n), .sw_rst_req (sw_rst_req), .wdt_rst_req (wdt_rst_req),
    .cause_clr (cause_clr), .dom_rst_n (dom_rst_n), .seq_busy (seq_busy),
    .seq_done (seq_done), .rst_cause (rst_cause)
  );

  rst_sequencer #(
    .NUM_DOMAINS (1), .SYNC_STAGES (3), .HOLD_CYCLES (1), .STAGE_GAP (1)
  ) dut_b (
    .clk (clk), .rst_n (rst_n_b), .sw_rst_req (sw_b), .wdt_rst_req (wdt_b),
    .cause_clr (clr_b), .dom_rst_n (dom_b), .seq_busy (busy_b),
    .seq_done (done_b), .rst_cause (cause_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int last_edge(input int base);
    return base + P_HOLD + (P_N - 1) * P_GAP;
  endfunction

  task automatic model_eval();
    for (int i = 0; i < P_N; i++) e_dom[i] = (m_n >= m_base + P_HOLD + i * P_GAP);
    e_busy  = (m_n <= last_edge(m_base));
    e_done  = (m_n == last_edge(m_base));
    e_cause = m_cause;
  endtask

  task automatic model_por();
    m_n     = 0;
    m_base  = P_SYNC;
    m_cause = 3'b001;
    model_eval();
  endtask

  // Drive one cycle of inputs, advance the model by the sampled edge, settle
  task automatic tick(input logic s, input logic w, input logic c);
    sw_rst_req  = s;
    wdt_rst_req = w;
    cause_clr   = c;
    @(posedge clk);
    m_n = m_n + 1;
    if (s || w) m_base = (m_n > P_SYNC) ? m_n : P_SYNC;
    if (c) m_cause = {w, s, 1'b0};
    else   m_cause = m_cause | {w, s, 1'b0};
    model_eval();
    #1;
    sw_rst_req  = 1'b0;
    wdt_rst_req = 1'b0;
    cause_clr   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      model_por();
      n_checks++;
      if ({dom_rst_n, seq_busy, seq_done, rst_cause} !== {e_dom, e_busy, e_done, e_cause})
        $display("FAIL reset: got dom=%b busy=%b done=%b cause=%b want dom=%b busy=%b done=%b cause=%b",
                 dom_rst_n, seq_busy, seq_done, rst_cause, e_dom, e_busy, e_done, e_cause);
      else n_pass++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_por();
    int dones = 0;
    for (int i = 0; i < 25; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (seq_done === 1'b1) dones++;
      n_checks++;
      if ({dom_rst_n, seq_busy, seq_done, rst_cause} !== {e_dom, e_busy, e_done, e_cause})
        $display("FAIL por edge %0d: got dom=%b busy=%b done=%b cause=%b want dom=%b busy=%b done=%b cause=%b",
                 m_n, dom_rst_n, seq_busy, seq_done, rst_cause, e_dom, e_busy, e_done, e_cause);
      else n_pass++;
    end
    n_checks++;
    if (dones !== 1) $display("FAIL por_done_count: got %0d want 1", dones);
    else n_pass++;
  endtask

  task automatic test_sw_run();
    int dones = 0;
    for (int i = 0; i < 22; i++) begin
      tick(i == 1, 1'b0, i == 0);
      if (seq_done === 1'b1) dones++;
      n_checks++;
      if ({dom_rst_n, seq_busy, seq_done, rst_cause} !== {e_dom, e_busy, e_done, e_cause})
        $display("FAIL sw_run edge %0d: got dom=%b busy=%b done=%b cause=%b want dom=%b busy=%b done=%b cause=%b",
                 m_n, dom_rst_n, seq_busy, seq_done, rst_cause, e_dom, e_busy, e_done, e_cause);
      else n_pass++;
    end
    n_checks++;
    if ({dones, rst_cause} !== {32'd1, 3'b010})
      $display("FAIL sw_run_summary: got done_count=%0d cause=%b want 1 and 010", dones, rst_cause);
    else n_pass++;
  endtask

  task automatic test_wdt_release();
    int dones = 0;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40 && e_dom !== 3'b001; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (seq_done === 1'b1) dones++;
    end
    n_checks++;
    if (dom_rst_n !== 3'b001) $display("FAIL wdt_pre: got dom=%b want 001", dom_rst_n);
    else n_pass++;
    for (int i = 0; i < 22; i++) begin
      tick(1'b0, i == 0, 1'b0);
      if (seq_done === 1'b1) dones++;
      n_checks++;
      if ({dom_rst_n, seq_busy, seq_done, rst_cause} !== {e_dom, e_busy, e_done, e_cause})
        $display("FAIL wdt_release edge %0d: got dom=%b busy=%b done=%b cause=%b want dom=%b busy=%b done=%b cause=%b",
                 m_n, dom_rst_n, seq_busy, seq_done, rst_cause, e_dom, e_busy, e_done, e_cause);
      else n_pass++;
    end
    n_checks++;
    if ({dones, rst_cause[2]} !== {32'd1, 1'b1})
      $display("FAIL wdt_summary: got done_count=%0d cause=%b want 1 and bit2 set", dones, rst_cause);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    int dones = 0;
    for (int i = 0; i < 22; i++) begin
      tick(i == 0, i == 0, i == 0);
      if (seq_done === 1'b1) dones++;
      n_checks++;
      if ({dom_rst_n, seq_busy, seq_done, rst_cause} !== {e_dom, e_busy, e_done, e_cause})
        $display("FAIL simultaneous edge %0d: got dom=%b busy=%b done=%b cause=%b want dom=%b busy=%b done=%b cause=%b",
                 m_n, dom_rst_n, seq_busy, seq_done, rst_cause, e_dom, e_busy, e_done, e_cause);
      else n_pass++;
    end
    n_checks++;
    if ({dones, rst_cause} !== {32'd1, 3'b110})
      $display("FAIL simultaneous_summary: got done_count=%0d cause=%b want 1 and 110", dones, rst_cause);
    else n_pass++;
  endtask

  task automatic test_async_mid();
    int dones = 0;
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40 && e_dom !== 3'b011; i++) tick(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (dom_rst_n !== 3'b011) $display("FAIL async_pre: got dom=%b want 011", dom_rst_n);
    else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    model_por();
    n_checks++;
    if ({dom_rst_n, seq_busy, seq_done, rst_cause} !== {e_dom, e_busy, e_done, e_cause})
      $display("FAIL async_drop: got dom=%b busy=%b done=%b cause=%b want dom=%b busy=%b done=%b cause=%b",
               dom_rst_n, seq_busy, seq_done, rst_cause, e_dom, e_busy, e_done, e_cause);
    else n_pass++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (seq_done === 1'b1) dones++;
      n_checks++;
      if ({dom_rst_n, seq_busy, seq_done, rst_cause} !== {e_dom, e_busy, e_done, e_cause})
        $display("FAIL async_repor edge %0d: got dom=%b busy=%b done=%b cause=%b want dom=%b busy=%b done=%b cause=%b",
                 m_n, dom_rst_n, seq_busy, seq_done, rst_cause, e_dom, e_busy, e_done, e_cause);
      else n_pass++;
    end
    n_checks++;
    if (dones !== 1) $display("FAIL async_done_count: got %0d want 1", dones);
    else n_pass++;
  endtask

  task automatic test_glitch();
    #2;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_por();
    for (int i = 0; i < 22; i++) begin
      tick(1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({dom_rst_n, seq_busy, seq_done, rst_cause} !== {e_dom, e_busy, e_done, e_cause})
        $display("FAIL glitch edge %0d: got dom=%b busy=%b done=%b cause=%b want dom=%b busy=%b done=%b cause=%b",
                 m_n, dom_rst_n, seq_busy, seq_done, rst_cause, e_dom, e_busy, e_done, e_cause);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic s, w, c;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 19) == 0);
      w = ($urandom_range(0, 24) == 0);
      c = ($urandom_range(0, 9) == 0);
      tick(s, w, c);
      n_checks++;
      if ({dom_rst_n, seq_busy, seq_done, rst_cause} !== {e_dom, e_busy, e_done, e_cause})
        $display("FAIL random cycle %0d: got dom=%b busy=%b done=%b cause=%b want dom=%b busy=%b done=%b cause=%b",
                 i, dom_rst_n, seq_busy, seq_done, rst_cause, e_dom, e_busy, e_done, e_cause);
      else n_pass++;
    end
  endtask

  task automatic test_sweep();
    n_checks++;
    if ({dom_b, busy_b, done_b, cause_b} !== {1'b0, 1'b1, 1'b0, 3'b001})
      $display("FAIL sweep_reset: got dom=%b busy=%b done=%b cause=%b want 0 1 0 001",
               dom_b, busy_b, done_b, cause_b);
    else n_pass++;
    @(negedge clk);
    rst_n_b = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({dom_b, busy_b, done_b} !== {e >= 4, e <= 4, e == 4})
        $display("FAIL sweep_por edge %0d: got dom=%b busy=%b done=%b want dom=%b busy=%b done=%b",
                 e, dom_b, busy_b, done_b, e >= 4, e <= 4, e == 4);
      else n_pass++;
    end
    sw_b = 1'b1;
    @(posedge clk);
    #1;
    sw_b = 1'b0;
    n_checks++;
    if ({dom_b, busy_b, done_b, cause_b} !== {1'b0, 1'b1, 1'b0, 3'b011})
      $display("FAIL sweep_req: got dom=%b busy=%b done=%b cause=%b want 0 1 0 011",
               dom_b, busy_b, done_b, cause_b);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({dom_b, busy_b, done_b} !== {1'b1, 1'b1, 1'b1})
      $display("FAIL sweep_rerelease: got dom=%b busy=%b done=%b want 1 1 1", dom_b, busy_b, done_b);
    else n_pass++;
    @(posedge clk);
    #1;
    n_checks++;
    if ({dom_b, busy_b, done_b} !== {1'b1, 1'b0, 1'b0})
      $display("FAIL sweep_idle: got dom=%b busy=%b done=%b want 1 0 0", dom_b, busy_b, done_b);
    else n_pass++;
  endtask

  initial begin
    rst_n       = 1'b0;
    sw_rst_req  = 1'b0;
    wdt_rst_req = 1'b0;
    cause_clr   = 1'b0;
    rst_n_b     = 1'b0;
    sw_b        = 1'b0;
    wdt_b       = 1'b0;
    clr_b       = 1'b0;
    test_reset();
    model_por();
    test_por();
    test_sw_run();
    test_wdt_release();
    test_simultaneous();
    test_async_mid();
    test_glitch();
    test_random();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Central reset controller for the simulation and SoC top level.
- Synchronizes deassertion of the external asynchronous reset and merges software and watchdog reset requests.
- Drives NUM_DOMAINS downstream reset outputs: asserted together, held for a minimum time, then released one after another in order, domain 0 first.
- Keeps a sticky reset-cause register that firmware and testbenches can read.

Parameters:
- NUM_DOMAINS, 3: number of sequenced reset outputs; legal range 1..8.
- SYNC_STAGES, 2: flops in the reset-deassertion synchronizer; minimum 2.
- HOLD_CYCLES, 8: cycles all domains stay asserted after the reset source is gone; minimum 1.
- STAGE_GAP, 4: cycles between consecutive domain releases; minimum 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  external reset; asynchronous, active-low.
- sw_rst_req  input  1  software reset request; single-cycle pulse, sampled on posedge clk.
- wdt_rst_req  input  1  watchdog reset request; single-cycle pulse, sampled on posedge clk.
- cause_clr  input  1  clears rst_cause when high at a posedge.
- dom_rst_n  output  NUM_DOMAINS  per-domain reset, active-low, registered.
- seq_busy  output  1  high while any domain is held in reset or still sequencing.
- seq_done  output  1  one-cycle pulse when the last domain is released.
- rst_cause  output  3  sticky cause bits: [2] wdt, [1] sw, [0] por.

Behaviour:
- Only one clock; every flop is asynchronously reset by rst_n low. No flop uses a synchronous reset.
- While rst_n is low:
  - dom_rst_n = 0, seq_busy = 1, seq_done = 0.
  - rst_cause = 3'b001; POR is set by the asynchronous reset value.
  - Synchronizer chain = 0, FSM = HOLD, counter = 0.
- Synchronizer: a SYNC_STAGES-deep chain shifts in 1 after rst_n rises, giving internal rst_sync_n. Assertion is immediate; deassertion appears after SYNC_STAGES edges.
- FSM states:
  - HOLD: all dom_rst_n = 0, seq_busy = 1. The counter increments only while rst_sync_n = 1. When the counter reaches HOLD_CYCLES, clear the counter, go to RELEASE and raise dom_rst_n[0] on that edge.
  - RELEASE: the counter counts STAGE_GAP cycles per step. At each step raise the next dom_rst_n[i]. Released bits stay at 1.
    - When dom_rst_n[NUM_DOMAINS-1] rises: go to RUN, pulse seq_done for that one cycle, drop seq_busy on the following edge.
    - With NUM_DOMAINS = 1, HOLD goes directly to RUN and the seq_done pulse coincides with the dom_rst_n[0] release.
  - RUN: dom_rst_n all ones, seq_busy = 0. Stays here until a request arrives.
- Timing with defaults (edge 1 = first posedge after rst_n rises):
  - rst_sync_n = 1 after edge 2.
  - dom_rst_n[0] rises at edge 10, [1] at edge 14, [2] at edge 18.
  - seq_done is high in the cycle after edge 18.
  - In general, domain i rises at edge SYNC_STAGES + HOLD_CYCLES + i*STAGE_GAP.
- Request handling:
  - A sw_rst_req or wdt_rst_req sampled at edge k in RUN or RELEASE drives all dom_rst_n to 0 at edge k, enters HOLD and clears the counter. dom_rst_n[0] then rises at edge k + HOLD_CYCLES.
  - A request during RELEASE aborts the sequence: already-released domains are re-asserted and no seq_done pulse is produced.
  - A request during HOLD restarts the hold counter at 0, which extends the hold.
  - sw and wdt requests in the same cycle are treated as a single reset; both cause bits are set.
- rst_cause update:
  - A request sets its bit at the sampling edge.
  - cause_clr zeroes all three bits.
  - If cause_clr and a request occur in the same cycle, the request's bit is set and the other bits are cleared.
  - rst_cause is reset only by rst_n, never by sequencer-initiated resets.
- Reset mid-operation: rst_n falling in any state asynchronously forces all outputs to reset values immediately, without waiting for a clock edge.
- A glitch on rst_n shorter than one clock period still produces a full POR sequence.

Test Plan:
- POR, defaults: hold rst_n low 5 cycles, then release → dom_rst_n = 000 through edge 9; 001 at 10, 011 at 14, 111 at 18. seq_done is high for exactly one cycle after edge 18, seq_busy falls at edge 19, rst_cause = 001.
- Software reset in RUN: cause_clr, then sw_rst_req at edge k → dom_rst_n = 000 at k, 001 at k+8, 111 at k+16. rst_cause = 010, one seq_done pulse.
- Watchdog during RELEASE: wdt_rst_req one cycle after dom_rst_n becomes 001 → all domains return to 000, no seq_done for the aborted sequence, re-release 8 cycles later. rst_cause has bit 2 set.
- Simultaneous events: sw_rst_req, wdt_rst_req and cause_clr in the same cycle → rst_cause = 110 and a single sequence runs.
- Async reset mid-sequence: pull rst_n low between clock edges while dom_rst_n = 011 → dom_rst_n = 000 and seq_busy = 1 without a clock edge. After release, the full POR timing is repeated.
- Parameter sweep NUM_DOMAINS = 1, HOLD_CYCLES = 1, STAGE_GAP = 1, SYNC_STAGES = 3 → dom_rst_n rises at edge 4, and seq_done pulses in the same cycle.
